// File: rtl/axil_axis_if.sv
// Bundled AXI-Lite master/slave and AXI-Stream in/out signals of the bridge.
// master = bridge view, slave = SoC / switch side view.
interface axil_axis_if;
    logic        m_awvalid, m_awready;
    logic [31:0] m_awaddr;
    logic        m_wvalid, m_wready;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_arvalid, m_arready;
    logic [31:0] m_araddr;
    logic        m_rvalid, m_rready;
    logic [31:0] m_rdata;

    logic        s_awvalid, s_awready;
    logic [14:0] s_awaddr;
    logic        s_wvalid, s_wready;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_arvalid, s_arready;
    logic [14:0] s_araddr;
    logic        s_rvalid, s_rready;
    logic [31:0] s_rdata;

    logic [31:0] as_aa_tdata;
    logic [3:0]  as_aa_tstrb, as_aa_tkeep;
    logic        as_aa_tlast, as_aa_tvalid;
    logic [1:0]  as_aa_tuser;
    logic        aa_as_tready;

    logic [31:0] aa_as_tdata;
    logic [3:0]  aa_as_tstrb, aa_as_tkeep;
    logic        aa_as_tlast, aa_as_tvalid;
    logic [1:0]  aa_as_tuser;
    logic        as_aa_tready;

    modport master (
        output m_awvalid, m_awaddr, m_wvalid, m_wdata, m_wstrb, m_arvalid, m_araddr, m_rready,
        input  m_awready, m_wready, m_arready, m_rvalid, m_rdata,
        input  s_awvalid, s_awaddr, s_wvalid, s_wdata, s_wstrb, s_arvalid, s_araddr, s_rready,
        output s_awready, s_wready, s_arready, s_rvalid, s_rdata,
        input  as_aa_tdata, as_aa_tstrb, as_aa_tkeep, as_aa_tlast, as_aa_tvalid, as_aa_tuser,
        output aa_as_tready,
        output aa_as_tdata, aa_as_tstrb, aa_as_tkeep, aa_as_tlast, aa_as_tvalid, aa_as_tuser,
        input  as_aa_tready
    );

    modport slave (
        input  m_awvalid, m_awaddr, m_wvalid, m_wdata, m_wstrb, m_arvalid, m_araddr, m_rready,
        output m_awready, m_wready, m_arready, m_rvalid, m_rdata,
        output s_awvalid, s_awaddr, s_wvalid, s_wdata, s_wstrb, s_arvalid, s_araddr, s_rready,
        input  s_awready, s_wready, s_arready, s_rvalid, s_rdata,
        output as_aa_tdata, as_aa_tstrb, as_aa_tkeep, as_aa_tlast, as_aa_tvalid, as_aa_tuser,
        input  aa_as_tready,
        input  aa_as_tdata, aa_as_tstrb, aa_as_tkeep, aa_as_tlast, aa_as_tvalid, aa_as_tuser,
        output as_aa_tready
    );
endinterface

// File: rtl/axil_axis.sv
// AXI-Lite <-> AXI-Stream bridge: local mailbox/interrupt registers, mailbox
// forwarding to the remote side, and execution of remote stream commands.
module axil_axis (
    input  logic        axis_clk,
    input  logic        axis_rst,
    input  logic        cc_aa_enable,
    output logic        mb_irq,
    axil_axis_if.master bus
);
    typedef enum logic [1:0] {R_IDLE, R_ACK, R_DATA} rd_st_t;
    typedef enum logic [2:0] {I_IDLE, I_DATA, I_DROP, I_MBW, I_LMW, I_LMR_A, I_LMR_D, I_RESP} ib_st_t;
    typedef enum logic [1:0] {O_IDLE, O_RESP, O_HDR, O_DAT} ob_st_t;

    rd_st_t rd_st, rd_nx;
    ib_st_t ib_st, ib_nx;
    ob_st_t ob_st, ob_nx;

    logic [31:0] mbox [8];
    logic        intr_en, intr_stat, rst_done;
    logic        ls_wr_ack, ls_wr_go, ls_wr_mb, w1c, rem_we;
    logic [2:0]  loc_idx, rem_idx;
    logic [31:0] loc_word, rd_word;
    logic [31:0] ib_addr, ib_data, resp_data;
    logic [3:0]  ib_strb;
    logic        aw_done, w_done, aw_hs, w_hs, ib_hs;
    logic        fwd_pend;
    logic [14:0] fwd_addr;
    logic [31:0] fwd_data;
    logic [3:0]  fwd_strb;
    logic        unused_ok;

    assign unused_ok = ^{bus.as_aa_tkeep, bus.s_araddr[1:0]};

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] s);
        merge = o;
        for (int b = 0; b < 4; b++) if (s[b]) merge[8*b +: 8] = n[8*b +: 8];
    endfunction

    // LS write side: the readies are one registered pulse per accepted write
    assign ls_wr_go  = bus.s_awvalid & bus.s_wvalid & cc_aa_enable & ~ls_wr_ack &
                       (ob_st == O_IDLE) & ~fwd_pend;
    assign ls_wr_mb  = (bus.s_awaddr[14:5] == 10'd0);
    assign loc_idx   = bus.s_awaddr[4:2];
    assign rem_idx   = ib_addr[4:2];
    assign rem_we    = (ib_st == I_MBW);
    assign w1c       = ls_wr_ack & (bus.s_awaddr[14:2] == 13'h041) & bus.s_wstrb[0] & bus.s_wdata[0];
    assign bus.s_awready = ls_wr_ack;
    assign bus.s_wready  = ls_wr_ack;

    // A colliding remote write takes the whole word, so the forward carries its result
    always_comb begin
        loc_word = merge(mbox[loc_idx], bus.s_wdata, bus.s_wstrb);
        if (rem_we && rem_idx == loc_idx) loc_word = merge(mbox[loc_idx], ib_data, ib_strb);
    end

    always_comb begin
        rd_word = 32'd0;
        if (bus.s_araddr[14:5] == 10'd0)         rd_word = mbox[bus.s_araddr[4:2]];
        else if (bus.s_araddr[14:2] == 13'h040)  rd_word = {31'd0, intr_en};
        else if (bus.s_araddr[14:2] == 13'h041)  rd_word = {31'd0, intr_stat};
    end

    always_comb begin
        rd_nx = rd_st;
        case (rd_st)
            R_IDLE:  if (bus.s_arvalid && cc_aa_enable) rd_nx = R_ACK;
            R_ACK:   rd_nx = R_DATA;
            R_DATA:  if (bus.s_rready) rd_nx = R_IDLE;
            default: rd_nx = R_IDLE;
        endcase
    end
    assign bus.s_arready = (rd_st == R_ACK);
    assign bus.s_rvalid  = (rd_st == R_DATA);

    // Inbound command engine
    assign bus.aa_as_tready = rst_done & (ib_st == I_IDLE || ib_st == I_DATA || ib_st == I_DROP);
    assign ib_hs = bus.as_aa_tvalid & bus.aa_as_tready;
    assign aw_hs = (ib_st == I_LMW) & ~aw_done & bus.m_awready;
    assign w_hs  = (ib_st == I_LMW) & ~w_done & bus.m_wready;

    always_comb begin
        ib_nx = ib_st;
        case (ib_st)
            I_IDLE: if (ib_hs) begin
                case (bus.as_aa_tuser)
                    2'b01:   ib_nx = I_DATA;
                    2'b10:   ib_nx = (bus.as_aa_tdata[31:5] == 27'd0) ? I_RESP : I_LMR_A;
                    default: ib_nx = bus.as_aa_tlast ? I_IDLE : I_DROP;
                endcase
            end
            I_DATA:  if (ib_hs) ib_nx = (ib_addr[31:5] == 27'd0) ? I_MBW : I_LMW;
            I_DROP:  if (ib_hs && bus.as_aa_tlast) ib_nx = I_IDLE;
            I_MBW:   ib_nx = I_IDLE;
            I_LMW:   if ((aw_done | aw_hs) && (w_done | w_hs)) ib_nx = I_IDLE;
            I_LMR_A: if (bus.m_arready) ib_nx = I_LMR_D;
            I_LMR_D: if (bus.m_rvalid) ib_nx = I_RESP;
            I_RESP:  if (ob_st == O_RESP && bus.as_aa_tready) ib_nx = I_IDLE;
            default: ib_nx = I_IDLE;
        endcase
    end
    assign bus.m_awvalid = (ib_st == I_LMW) & ~aw_done;
    assign bus.m_wvalid  = (ib_st == I_LMW) & ~w_done;
    assign bus.m_arvalid = (ib_st == I_LMR_A);
    assign bus.m_rready  = (ib_st == I_LMR_D);
    assign bus.m_awaddr  = ib_addr;
    assign bus.m_araddr  = ib_addr;
    assign bus.m_wdata   = ib_data;
    assign bus.m_wstrb   = ib_strb;

    // Outbound engine: a pending read response goes ahead of a queued forward
    always_comb begin
        ob_nx = ob_st;
        bus.aa_as_tvalid = 1'b0;
        bus.aa_as_tdata  = 32'd0;
        bus.aa_as_tstrb  = 4'h0;
        bus.aa_as_tkeep  = 4'h0;
        bus.aa_as_tlast  = 1'b0;
        bus.aa_as_tuser  = 2'b00;
        case (ob_st)
            O_IDLE: begin
                if (ib_st == I_RESP) ob_nx = O_RESP;
                else if (fwd_pend)   ob_nx = O_HDR;
            end
            O_RESP: begin
                bus.aa_as_tvalid = 1'b1;
                bus.aa_as_tdata  = resp_data;
                bus.aa_as_tstrb  = 4'hF;
                bus.aa_as_tkeep  = 4'hF;
                bus.aa_as_tlast  = 1'b1;
                bus.aa_as_tuser  = 2'b11;
                if (bus.as_aa_tready) ob_nx = O_IDLE;
            end
            O_HDR: begin
                bus.aa_as_tvalid = 1'b1;
                bus.aa_as_tdata  = {17'd0, fwd_addr};
                bus.aa_as_tstrb  = 4'hF;
                bus.aa_as_tkeep  = 4'hF;
                bus.aa_as_tuser  = 2'b01;
                if (bus.as_aa_tready) ob_nx = O_DAT;
            end
            O_DAT: begin
                bus.aa_as_tvalid = 1'b1;
                bus.aa_as_tdata  = fwd_data;
                bus.aa_as_tstrb  = fwd_strb;
                bus.aa_as_tkeep  = 4'hF;
                bus.aa_as_tlast  = 1'b1;
                bus.aa_as_tuser  = 2'b01;
                if (bus.as_aa_tready) ob_nx = O_IDLE;
            end
            default: ob_nx = O_IDLE;
        endcase
    end

    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            for (int i = 0; i < 8; i++) mbox[i] <= 32'd0;
            rd_st       <= R_IDLE;
            ib_st       <= I_IDLE;
            ob_st       <= O_IDLE;
            intr_en     <= 1'b0;
            intr_stat   <= 1'b0;
            mb_irq      <= 1'b0;
            rst_done    <= 1'b0;
            ls_wr_ack   <= 1'b0;
            bus.s_rdata <= 32'd0;
            ib_addr     <= 32'd0;
            ib_data     <= 32'd0;
            ib_strb     <= 4'h0;
            resp_data   <= 32'd0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            fwd_pend    <= 1'b0;
            fwd_addr    <= 15'd0;
            fwd_data    <= 32'd0;
            fwd_strb    <= 4'h0;
        end else begin
            rd_st     <= rd_nx;
            ib_st     <= ib_nx;
            ob_st     <= ob_nx;
            rst_done  <= 1'b1;
            ls_wr_ack <= ls_wr_go;

            if (ls_wr_ack) begin
                if (ls_wr_mb) begin
                    mbox[loc_idx] <= loc_word;
                    fwd_pend      <= 1'b1;
                    fwd_addr      <= bus.s_awaddr;
                    fwd_data      <= loc_word;
                    fwd_strb      <= bus.s_wstrb;
                end
                if (bus.s_awaddr[14:2] == 13'h040 && bus.s_wstrb[0]) intr_en <= bus.s_wdata[0];
            end
            if (rem_we) mbox[rem_idx] <= merge(mbox[rem_idx], ib_data, ib_strb);
            intr_stat <= rem_we | (intr_stat & ~w1c);
            mb_irq    <= intr_en & intr_stat;
            if (ob_st == O_DAT && bus.as_aa_tready) fwd_pend <= 1'b0;

            if (rd_st == R_ACK) bus.s_rdata <= rd_word;

            if (ib_st == I_IDLE && ib_hs) begin
                ib_addr <= bus.as_aa_tdata;
                if (bus.as_aa_tuser == 2'b10 && bus.as_aa_tdata[31:5] == 27'd0)
                    resp_data <= mbox[bus.as_aa_tdata[4:2]];
            end
            if (ib_st == I_DATA && ib_hs) begin
                ib_data <= bus.as_aa_tdata;
                ib_strb <= bus.as_aa_tstrb;
            end
            if (ib_st == I_LMR_D && bus.m_rvalid) resp_data <= bus.m_rdata;
            if (ib_st == I_LMW && ib_nx == I_IDLE) begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end else begin
                if (aw_hs) aw_done <= 1'b1;
                if (w_hs)  w_done  <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_axil_axis.sv
// Directed bench for axil_axis; expected responses are queued when stimulus is
// issued and popped by negedge monitors when the DUT presents them.
module tb_axil_axis;
    logic axis_clk = 1'b0;
    logic axis_rst = 1'b1;
    logic cc_aa_enable = 1'b1;
    logic mb_irq;

    axil_axis_if bus();

    axil_axis dut (
        .axis_clk     (axis_clk),
        .axis_rst     (axis_rst),
        .cc_aa_enable (cc_aa_enable),
        .mb_irq       (mb_irq),
        .bus          (bus)
    );

    always #5 axis_clk = ~axis_clk;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  s;
        logic [1:0]  u;
        logic        l;
    } beat_t;

    beat_t       ob_q[$];
    logic [31:0] rd_q[$];
    logic [31:0] aw_q[$];
    logic [35:0] w_q[$];
    beat_t       ob_e;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitors
    always @(negedge axis_clk) begin
        if (!axis_rst && bus.aa_as_tvalid && bus.as_aa_tready) begin
            if (ob_q.size() == 0) chk("ob_unexpected_beat", ob_q.size(), 1);
            else begin
                ob_e = ob_q.pop_front();
                chk("ob_tdata", bus.aa_as_tdata, ob_e.d);
                chk("ob_keep_strb_user_last",
                    {21'd0, bus.aa_as_tkeep, bus.aa_as_tstrb, bus.aa_as_tuser, bus.aa_as_tlast},
                    {21'd0, 4'hF, ob_e.s, ob_e.u, ob_e.l});
            end
        end
        if (!axis_rst && bus.s_rvalid && bus.s_rready) begin
            if (rd_q.size() == 0) chk("rd_unexpected", rd_q.size(), 1);
            else chk("ls_rdata", bus.s_rdata, rd_q.pop_front());
        end
        if (!axis_rst && bus.m_awvalid && bus.m_awready) begin
            if (aw_q.size() == 0) chk("lm_aw_unexpected", aw_q.size(), 1);
            else chk("lm_awaddr", bus.m_awaddr, aw_q.pop_front());
        end
        if (!axis_rst && bus.m_wvalid && bus.m_wready) begin
            if (w_q.size() == 0) chk("lm_w_unexpected", w_q.size(), 1);
            else chk("lm_wdata_wstrb", {bus.m_wstrb, bus.m_wdata}, w_q.pop_front());
        end
    end

    // Stimulus tasks: entered and left just after a rising edge
    task automatic ls_wr_start(input logic [14:0] a, input logic [31:0] d, input logic [3:0] s);
        bus.s_awvalid = 1'b1; bus.s_awaddr = a;
        bus.s_wvalid  = 1'b1; bus.s_wdata  = d; bus.s_wstrb = s;
    endtask

    task automatic ls_wr_finish();
        int n = 0;
        @(negedge axis_clk);
        while (!bus.s_awready && n < 50) begin @(negedge axis_clk); n++; end
        chk("ls_wr_ready_pair", {30'd0, bus.s_awready, bus.s_wready}, 32'd3);
        @(posedge axis_clk); #1;
        bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0;
        @(negedge axis_clk);
        chk("ls_wr_ready_pulse", {30'd0, bus.s_awready, bus.s_wready}, 32'd0);
        @(posedge axis_clk); #1;
    endtask

    task automatic ls_write(input logic [14:0] a, input logic [31:0] d, input logic [3:0] s);
        ls_wr_start(a, d, s);
        ls_wr_finish();
    endtask

    task automatic ls_read(input logic [14:0] a, input logic [31:0] exp);
        int n = 0;
        rd_q.push_back(exp);
        bus.s_arvalid = 1'b1; bus.s_araddr = a;
        @(negedge axis_clk);
        while (!bus.s_arready && n < 50) begin @(negedge axis_clk); n++; end
        chk("ls_arready", {31'd0, bus.s_arready}, 32'd1);
        @(posedge axis_clk); #1;
        bus.s_arvalid = 1'b0;
        n = 0;
        while (rd_q.size() != 0 && n < 20) begin @(posedge axis_clk); n++; end
        #1;
        chk("ls_rd_done", rd_q.size(), 0);
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [3:0] s, input logic [1:0] u,
                             input logic l);
        int n = 0;
        bus.as_aa_tvalid = 1'b1; bus.as_aa_tdata = d; bus.as_aa_tstrb = s;
        bus.as_aa_tkeep  = 4'hF; bus.as_aa_tuser = u; bus.as_aa_tlast = l;
        @(negedge axis_clk);
        while (!bus.aa_as_tready && n < 50) begin @(negedge axis_clk); n++; end
        chk("ib_tready", {31'd0, bus.aa_as_tready}, 32'd1);
        @(posedge axis_clk); #1;
        bus.as_aa_tvalid = 1'b0;
    endtask

    task automatic wait_ob_empty();
        int n = 0;
        while (ob_q.size() != 0 && n < 50) begin @(posedge axis_clk); n++; end
        #1;
        chk("ob_drain", ob_q.size(), 0);
    endtask

    task automatic push_ob(input logic [31:0] d, input logic [3:0] s, input logic [1:0] u,
                           input logic l);
        beat_t b;
        b.d = d; b.s = s; b.u = u; b.l = l;
        ob_q.push_back(b);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic any_rdy;
        bus.m_awready = 0; bus.m_wready = 0; bus.m_arready = 0; bus.m_rvalid = 0; bus.m_rdata = 0;
        bus.s_awvalid = 0; bus.s_awaddr = 0; bus.s_wvalid = 0; bus.s_wdata = 0; bus.s_wstrb = 0;
        bus.s_arvalid = 0; bus.s_araddr = 0; bus.s_rready = 1;
        bus.as_aa_tdata = 0; bus.as_aa_tstrb = 0; bus.as_aa_tkeep = 0; bus.as_aa_tlast = 0;
        bus.as_aa_tvalid = 0; bus.as_aa_tuser = 0; bus.as_aa_tready = 1;

        // Reset state
        repeat (3) @(posedge axis_clk);
        @(negedge axis_clk);
        chk("rst_ls_readies", {28'd0, bus.s_awready, bus.s_wready, bus.s_arready, bus.s_rvalid}, 32'd0);
        chk("rst_stream", {29'd0, bus.aa_as_tvalid, bus.aa_as_tready, mb_irq}, 32'd0);
        chk("rst_lm_valids", {28'd0, bus.m_awvalid, bus.m_wvalid, bus.m_arvalid, bus.m_rready}, 32'd0);
        chk("rst_tdata", bus.aa_as_tdata, 32'd0);
        @(posedge axis_clk); #1;
        axis_rst = 1'b0;
        repeat (2) @(posedge axis_clk); #1;

        // intr_enable write and readback; unmapped write ignored, unmapped read 0
        ls_write(15'h100, 32'h1, 4'b0001);
        ls_read(15'h100, 32'h1);
        ls_write(15'h180, 32'hFFFF_FFFF, 4'hF);
        ls_read(15'h200, 32'h0);
        ls_read(15'h100, 32'h1);

        // Local mailbox write is forwarded
        push_ob(32'h8, 4'hF, 2'b01, 1'b0);
        push_ob(32'hA5A5_A5A5, 4'hF, 2'b01, 1'b1);
        ls_write(15'h008, 32'hA5A5_A5A5, 4'hF);
        wait_ob_empty();
        chk("irq_after_local_write", {31'd0, mb_irq}, 32'd0);
        ls_read(15'h008, 32'hA5A5_A5A5);

        // Partial strobe: forward carries whole post-write word, strobes as written
        push_ob(32'h8, 4'hF, 2'b01, 1'b0);
        push_ob(32'hA5A5_A5FF, 4'b0001, 2'b01, 1'b1);
        ls_write(15'h008, 32'h0000_00FF, 4'b0001);
        wait_ob_empty();
        ls_read(15'h008, 32'hA5A5_A5FF);

        // Remote mailbox write sets interrupt; W1C clears it
        send_beat(32'h4, 4'hF, 2'b01, 1'b0);
        send_beat(32'h1234_5678, 4'hF, 2'b01, 1'b1);
        repeat (3) @(posedge axis_clk);
        @(negedge axis_clk);
        chk("irq_after_remote_write", {31'd0, mb_irq}, 32'd1);
        @(posedge axis_clk); #1;
        ls_read(15'h004, 32'h1234_5678);
        ls_read(15'h104, 32'h1);
        ls_write(15'h104, 32'h1, 4'b0001);
        @(posedge axis_clk);
        @(negedge axis_clk);
        chk("irq_after_w1c", {31'd0, mb_irq}, 32'd0);
        @(posedge axis_clk); #1;

        // Remote mailbox read; unknown tuser dropped
        push_ob(32'h1234_5678, 4'hF, 2'b11, 1'b1);
        send_beat(32'h4, 4'hF, 2'b10, 1'b1);
        wait_ob_empty();
        send_beat(32'h4, 4'hF, 2'b00, 1'b1);
        repeat (4) @(posedge axis_clk); #1;
        ls_read(15'h004, 32'h1234_5678);

        // LM write with split address/data acceptance
        aw_q.push_back(32'h3000_0000);
        w_q.push_back({4'b1100, 32'hDEAD_0000});
        send_beat(32'h3000_0000, 4'hF, 2'b01, 1'b0);
        send_beat(32'hDEAD_0000, 4'b1100, 2'b01, 1'b1);
        @(negedge axis_clk);
        chk("lm_valids_together", {30'd0, bus.m_awvalid, bus.m_wvalid}, 32'd3);
        chk("lm_wr_tready_low0", {31'd0, bus.aa_as_tready}, 32'd0);
        @(posedge axis_clk); #1;
        bus.m_awready = 1'b1;
        @(posedge axis_clk); #1;
        bus.m_awready = 1'b0;
        @(negedge axis_clk);
        chk("lm_aw_dropped_w_held", {29'd0, bus.m_awvalid, bus.m_wvalid, bus.aa_as_tready}, 32'd2);
        repeat (2) @(posedge axis_clk); #1;
        bus.m_wready = 1'b1;
        @(posedge axis_clk); #1;
        bus.m_wready = 1'b0;
        @(negedge axis_clk);
        chk("lm_wr_done", {29'd0, bus.m_awvalid, bus.m_wvalid, bus.aa_as_tready}, 32'd1);
        chk("lm_wr_single", aw_q.size() + w_q.size(), 0);
        @(posedge axis_clk); #1;

        // LM read, response held under backpressure
        bus.as_aa_tready = 1'b0;
        send_beat(32'h3000_0010, 4'hF, 2'b10, 1'b1);
        @(negedge axis_clk);
        chk("lm_arvalid", {31'd0, bus.m_arvalid}, 32'd1);
        chk("lm_araddr", bus.m_araddr, 32'h3000_0010);
        @(posedge axis_clk); #1;
        bus.m_arready = 1'b1;
        @(posedge axis_clk); #1;
        bus.m_arready = 1'b0;
        repeat (3) @(posedge axis_clk); #1;
        bus.m_rvalid = 1'b1; bus.m_rdata = 32'hCAFE_F00D;
        @(posedge axis_clk); #1;
        bus.m_rvalid = 1'b0; bus.m_rdata = 32'h0;
        @(posedge axis_clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge axis_clk);
            chk("resp_held_tvalid", {31'd0, bus.aa_as_tvalid}, 32'd1);
            chk("resp_held_tdata", bus.aa_as_tdata, 32'hCAFE_F00D);
        end
        push_ob(32'hCAFE_F00D, 4'hF, 2'b11, 1'b1);
        @(posedge axis_clk); #1;
        bus.as_aa_tready = 1'b1;
        wait_ob_empty();

        // Enable low stalls a pending LS write
        cc_aa_enable = 1'b0;
        push_ob(32'hC, 4'hF, 2'b01, 1'b0);
        push_ob(32'h1122_3344, 4'hF, 2'b01, 1'b1);
        ls_wr_start(15'h00C, 32'h1122_3344, 4'hF);
        any_rdy = 1'b0;
        repeat (5) begin
            @(negedge axis_clk);
            any_rdy = any_rdy | bus.s_awready | bus.s_wready;
        end
        chk("ls_stall_no_ready", {31'd0, any_rdy}, 32'd0);
        @(posedge axis_clk); #1;
        cc_aa_enable = 1'b1;
        ls_wr_finish();
        wait_ob_empty();
        ls_read(15'h00C, 32'h1122_3344);

        repeat (3) @(posedge axis_clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
